alu_scan_ctrl: RTL and testbench
================================

# alu_scan_ctrl

Sequencer that walks the ALU through all eight opcodes on a latched operand pair and feeds each captured result to the seven-segment `display` block. It sits between the switch/button inputs and the ALU/display pair. It issues one ALU request per opcode and waits for the ALU's acknowledge. It then holds `{opcodesel, result}` on the display for a programmable dwell before moving to the next opcode.

## Interface
- DWELL, 25_000_000: cycles each opcode/result pair is shown (≥2)
- TIMEOUT, 15: max cycles to wait for `alu_ack` before flagging an error (≥1)

Ports:
- clk_in  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  level-sampled; begins a scan when idle
- auto  in  1  1 = restart at opcode 0 after opcode 7; 0 = stop after opcode 7
- hold  in  1  1 = freeze dwell counter (pause)
- a_in, b_in  in  6 each  operands (two's complement), latched on accepted start
- alu_ack  in  1  ALU result valid
- alu_result  in  6  ALU result (two's complement)
- alu_op  out  3  opcode presented to the ALU
- alu_a, alu_b  out  6 each  latched operands to the ALU
- alu_req  out  1  one-cycle request pulse
- disp_result  out  6  result to `display.result`
- disp_opcodesel  out  3  opcode to `display.opcodesel`
- disp_blank  out  1  1 until the first result is captured after reset
- busy  out  1  high in ISSUE/WAIT/SHOW
- done  out  1  one-cycle pulse at end of a non-auto scan
- err  out  1  sticky ALU timeout flag

## Operation
- All outputs are registered. Reset values: state IDLE, alu_op=0, alu_a=alu_b=0, alu_req=0, disp_result=0, disp_opcodesel=0, disp_blank=1, busy=0, done=0, err=0, counters=0.
- IDLE: when start=1, latch a_in/b_in into alu_a/alu_b, set op=0, clear err, then go to ISSUE.
- ISSUE: drive alu_req=1 and alu_op=op for exactly one cycle. Load wait counter=0. Go to WAIT.
- WAIT: alu_ack is sampled only in this state; an ack during ISSUE is ignored.
  - alu_ack=1: disp_result←alu_result unchanged (no sign manipulation), disp_opcodesel←op, disp_blank←0, dwell=0, go to SHOW.
  - Wait counter reaches TIMEOUT-1 without ack: err←1, disp_result←6'b100000, disp_opcodesel←op, disp_blank←0, go to SHOW.
- SHOW: dwell increments only when hold=0. On the cycle dwell==DWELL-1 with hold=0:
  - op<7: op←op+1, go to ISSUE.
  - op==7 and auto=1: op←0, go to ISSUE. Operands are not re-latched and err is kept.
  - op==7 and auto=0: done=1 for one cycle, go to IDLE. The display keeps the last pair.
- start while busy is ignored; operands and op are unchanged.
- auto is sampled only at the op==7 dwell expiry.
- Dwell counter width is $clog2(DWELL). Wait counter width is $clog2(TIMEOUT+1). op wraps 7→0 only via auto.
- reset_n low at any time, including mid-WAIT or SHOW, forces reset values immediately. No alu_req follows until a new start after release.

## Timing
- start sampled at edge k → alu_req high from edge k to k+1, and alu_op is valid in that same cycle.
- alu_ack sampled at edge j (WAIT) → disp_result/disp_opcodesel/disp_blank update after edge j.
- Per opcode with ALU ack latency L (ack first sampled L edges after the req edge): 1 + L + DWELL cycles, plus one cycle per hold-high cycle during SHOW.
- Timeout path per opcode: 1 + TIMEOUT + DWELL cycles.
- busy rises after the accepted-start edge and falls on the same edge that done rises.

## Test plan
- DWELL=4, TIMEOUT=8, ALU model acks 1 cycle after req with result=op*4+1; start with a=5, b=3 → exactly 8 alu_req pulses, alu_a=5, alu_b=3 throughout, disp_opcodesel 0..7 each held 4 cycles, disp_result 1,5,…,29, single done pulse, busy then 0, display retains (7,29).
- Same setup with auto=1 → after op7's dwell, alu_req is reissued with alu_op=0 and no start. No done pulse. busy stays 1.
- hold=1 for 10 cycles during op2 SHOW → op2 shown exactly 14 cycles; alu_req for op3 delayed by 10 cycles.
- ALU model never acks op3 → err=1 after 8 WAIT cycles, disp_result=6'b100000, op4 proceeds normally. A new start after done clears err.
- ALU returns -15 (6'b110001) for op0 → disp_result=6'b110001 exactly. A start pulse with new a/b mid-scan leaves alu_a/alu_b unchanged.
- reset_n low during WAIT of op5 → all outputs at reset values immediately, disp_blank=1. No further alu_req after release until start.

Source files
------------

// File: rtl/alu_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_scan_ctrl
//  Description : Steps the ALU through opcodes 0..7 on one latched operand
//                pair. For each opcode it issues a single-cycle request, waits
//                (bounded) for the acknowledge, and then holds {opcode, result}
//                on the seven-segment display for DWELL cycles. A missing
//                acknowledge sets a sticky error flag and displays 6'b100000.
//  Ports       : clk_in, reset_n        - clock, async active-low reset
//                start, auto, hold      - scan control (start / loop / pause)
//                a_in, b_in             - operands, latched on accepted start
//                alu_ack, alu_result    - ALU handshake and result
//                alu_op, alu_a, alu_b,
//                alu_req                - ALU request side
//                disp_result, disp_opcodesel,
//                disp_blank             - display side
//                busy, done, err        - status
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_scan_ctrl #(
    parameter int DWELL   = 25_000_000,
    parameter int TIMEOUT = 15
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       start,
    input  logic       auto,
    input  logic       hold,
    input  logic [5:0] a_in,
    input  logic [5:0] b_in,
    input  logic       alu_ack,
    input  logic [5:0] alu_result,
    output logic [2:0] alu_op,
    output logic [5:0] alu_a,
    output logic [5:0] alu_b,
    output logic       alu_req,
    output logic [5:0] disp_result,
    output logic [2:0] disp_opcodesel,
    output logic       disp_blank,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] C_DWELL_LAST = DW'(DWELL - 1);
    localparam logic [WW-1:0] C_WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [5:0]    C_ERR_CODE   = 6'b100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [5:0]    a_q, a_d, b_q, b_d;
    logic          req_q, req_d;
    logic [5:0]    res_q, res_d;
    logic [2:0]    osel_q, osel_d;
    logic          blank_q, blank_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        req_d   = 1'b0;
        res_d   = res_q;
        osel_d  = osel_q;
        blank_d = blank_q;
        done_d  = 1'b0;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = 3'd0;
                    err_d   = 1'b0;
                    // The request is raised on the transition so that it is
                    // high for exactly the ISSUE cycle.
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_ack) begin
                    res_d   = alu_result;
                    osel_d  = op_q;
                    blank_d = 1'b0;
                    dcnt_d  = '0;
                    state_d = SHOW;
                end else if (wcnt_q == C_WAIT_LAST) begin
                    err_d   = 1'b1;
                    res_d   = C_ERR_CODE;
                    osel_d  = op_q;
                    blank_d = 1'b0;
                    dcnt_d  = '0;
                    state_d = SHOW;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (!hold) begin
                    if (dcnt_q == C_DWELL_LAST) begin
                        if (op_q != 3'd7) begin
                            op_d    = op_q + 3'd1;
                            req_d   = 1'b1;
                            state_d = ISSUE;
                        end else if (auto) begin
                            op_d    = 3'd0;
                            req_d   = 1'b1;
                            state_d = ISSUE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            req_q   <= 1'b0;
            res_q   <= '0;
            osel_q  <= '0;
            blank_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            req_q   <= req_d;
            res_q   <= res_d;
            osel_q  <= osel_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign alu_op         = op_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_req        = req_q;
    assign disp_result    = res_q;
    assign disp_opcodesel = osel_q;
    assign disp_blank     = blank_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_scan_ctrl
//  Description : Directed self-checking bench for alu_scan_ctrl with a small
//                ALU model and a scoreboard of expected display pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_scan_ctrl;

    localparam int DWELL   = 4;
    localparam int TIMEOUT = 8;

    logic       clk_in = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, auto = 1'b0, hold = 1'b0;
    logic [5:0] a_in = '0, b_in = '0;
    logic       alu_ack = 1'b0;
    logic [5:0] alu_result = '0;
    logic [2:0] alu_op;
    logic [5:0] alu_a, alu_b;
    logic       alu_req;
    logic [5:0] disp_result;
    logic [2:0] disp_opcodesel;
    logic       disp_blank, busy, done, err;

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    logic [5:0] ea, eb;
    logic [8:0] sb[$];

    alu_scan_ctrl #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .start(start), .auto(auto),
        .hold(hold), .a_in(a_in), .b_in(b_in), .alu_ack(alu_ack),
        .alu_result(alu_result), .alu_op(alu_op), .alu_a(alu_a),
        .alu_b(alu_b), .alu_req(alu_req), .disp_result(disp_result),
        .disp_opcodesel(disp_opcodesel), .disp_blank(disp_blank),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (alu_req) req_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [5:0] exp_res(input logic [2:0] op, input bit neg0);
        if (neg0 && op == 3'd0) return 6'b110001;
        return {op, 2'b01} + 6'd0;  // op*4+1
    endfunction

    // Accepted start: after this the bench sits in the ISSUE cycle of op0.
    task automatic do_start(input logic [5:0] a, input logic [5:0] b);
        a_in = a; b_in = b; start = 1'b1;
        step();
        start = 1'b0;
        ea = a; eb = b;
        chk("start_busy", busy, 1);
        chk("start_err_clr", err, 0);
    endtask

    // Entered in the ISSUE cycle of op; returns where the next req or done is visible.
    task automatic do_opcode(input logic [2:0] op, input bit ack, input logic [5:0] res,
                             input int hold_n);
        logic [8:0] e;
        int n;
        chk("req_hi", alu_req, 1);
        chk("req_op", alu_op, op);
        chk("op_a", alu_a, ea);
        chk("op_b", alu_b, eb);
        if (ack) begin
            step();
            chk("req_pulse", alu_req, 0);
            alu_ack = 1'b1; alu_result = res;
            sb.push_back({op, res});
            step();
            alu_ack = 1'b0;
        end else begin
            sb.push_back({op, 6'b100000});
            for (int i = 0; i < TIMEOUT; i++) step();
            chk("err_before_to", err, 0);
            step();
            chk("err_after_to", err, 1);
        end
        e = sb.pop_front();
        chk("disp_sel", disp_opcodesel, e[8:6]);
        chk("disp_res", disp_result, e[5:0]);
        chk("disp_blank", disp_blank, 0);
        if (hold_n > 0) begin
            // Pause the dwell and try a start with new operands; both must be ignored/frozen.
            hold = 1'b1; start = 1'b1; a_in = 6'h2A; b_in = 6'h15;
            for (int i = 0; i < hold_n; i++) step();
            hold = 1'b0; start = 1'b0;
        end
        n = hold_n;
        while (!alu_req && !done && n < 100) begin
            step();
            n++;
        end
        chk("dwell_len", n, DWELL + hold_n);
    endtask

    task automatic lap(input bit autom, input bit neg0, input int hold_op,
                       input int noack_op, input int stop_at);
        auto = autom;
        for (int op = 0; op < 8; op++) begin
            if (op == stop_at) begin
                chk("stop_req", alu_req, 1);
                chk("stop_op", alu_op, op[2:0]);
                return;
            end
            do_opcode(op[2:0], op != noack_op, exp_res(op[2:0], neg0),
                      (op == hold_op) ? 10 : 0);
        end
        if (autom) begin
            chk("auto_req", alu_req, 1);
            chk("auto_op0", alu_op, 0);
            chk("auto_nodone", done, 0);
            chk("auto_busy", busy, 1);
        end else begin
            chk("done_hi", done, 1);
            chk("done_busy", busy, 0);
            chk("done_noreq", alu_req, 0);
            step();
            chk("done_pulse", done, 0);
        end
    endtask

    initial begin
        int base;
        step();
        chk("rst_op", alu_op, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_req", alu_req, 0);
        chk("rst_res", disp_result, 0);
        chk("rst_blank", disp_blank, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;
        step(); step();

        // Single non-auto scan.
        base = req_cnt;
        do_start(6'd5, 6'd3);
        lap(1'b0, 1'b0, -1, -1, -1);
        chk("req_count", req_cnt - base, 8);
        step(); step();
        chk("keep_sel", disp_opcodesel, 7);
        chk("keep_res", disp_result, 29);
        chk("idle_busy", busy, 0);
        chk("keep_a", alu_a, 5);
        chk("keep_b", alu_b, 3);

        // Auto lap, then a second lap with hold on op2, no ack on op3.
        do_start(6'd5, 6'd3);
        lap(1'b1, 1'b0, -1, -1, -1);
        lap(1'b0, 1'b0, 2, 3, -1);
        chk("err_sticky", err, 1);

        // New start clears err; negative result on op0; reset during WAIT of op5.
        do_start(6'd7, 6'd2);
        lap(1'b0, 1'b1, -1, -1, 5);
        step();
        reset_n = 1'b0;
        #1;
        chk("arst_op", alu_op, 0);
        chk("arst_a", alu_a, 0);
        chk("arst_b", alu_b, 0);
        chk("arst_res", disp_result, 0);
        chk("arst_sel", disp_opcodesel, 0);
        chk("arst_blank", disp_blank, 1);
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        step(); step();
        reset_n = 1'b1;
        base = req_cnt;
        for (int i = 0; i < 20; i++) step();
        chk("no_req_after_rst", req_cnt - base, 0);
        chk("idle_after_rst", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
